vga_sync_generator: RTL and testbench

- Produces the VGA scan timing consumed by the ImageDrawer pixel logic: `row`, `column`, `enable`, `hsync` and `vsync` for 640x480@60.
- Derives the pixel rate from the system clock with a tick divider.
- Runs horizontal and vertical counters through active, front porch, sync and back porch regions.
- All outputs are registered and mutually aligned.

---
 rtl/vga_sync_generator.sv | 144 ++++++++++++++
 tb/tb_vga_sync_generator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_generator.sv
// rtl/vga_sync_generator.sv - VGA 640x480@60 scan timing generator; define VGA_FRAME_COUNTER_EN to add frame_count
module vga_sync_generator #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int CLK_DIV         = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] row,
  output logic [15:0] column,
  output logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        pixel_tick,
  output logic        frame_start
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_count
`endif
);

  // Region boundaries: the first counter value of each region, plus the last value of the axis.
  localparam logic [15:0] H_FRONT_START = 16'(H_ACTIVE);
  localparam logic [15:0] H_SYNC_START  = 16'(H_ACTIVE + H_FRONT);
  localparam logic [15:0] H_BACK_START  = 16'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [15:0] H_LAST        = 16'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [15:0] V_FRONT_START = 16'(V_ACTIVE);
  localparam logic [15:0] V_SYNC_START  = 16'(V_ACTIVE + V_FRONT);
  localparam logic [15:0] V_BACK_START  = 16'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [15:0] V_LAST        = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [15:0] DIV_LAST      = 16'(CLK_DIV - 1);
  localparam logic        SYNC_IDLE     = SYNC_ACTIVE_LOW;
  localparam logic        SYNC_ON       = ~SYNC_ACTIVE_LOW;

  typedef enum logic [1:0] {ST_ACTIVE, ST_FRONT, ST_SYNC, ST_BACK} region_t;

  // Region containing a position; used only to pick the state matching the reset position.
  function automatic region_t region_of(logic [15:0] pos, logic [15:0] front_s,
                                        logic [15:0] sync_s, logic [15:0] back_s);
    if (pos >= back_s)       return ST_BACK;
    else if (pos >= sync_s)  return ST_SYNC;
    else if (pos >= front_s) return ST_FRONT;
    else                     return ST_ACTIVE;
  endfunction

  // Region after the counter moves to nxt. Later boundaries are tested first so that a
  // zero-width region is skipped rather than entered.
  function automatic region_t next_region(region_t cur, logic [15:0] nxt, logic [15:0] front_s,
                                          logic [15:0] sync_s, logic [15:0] back_s);
    if (nxt == 16'd0)         return ST_ACTIVE;
    else if (nxt == back_s)   return ST_BACK;
    else if (nxt == sync_s)   return ST_SYNC;
    else if (nxt == front_s)  return ST_FRONT;
    else                      return cur;
  endfunction

  localparam region_t H_RESET_REGION = region_of(H_LAST, H_FRONT_START, H_SYNC_START, H_BACK_START);
  localparam region_t V_RESET_REGION = region_of(V_LAST, V_FRONT_START, V_SYNC_START, V_BACK_START);

  logic [15:0] div;
  logic        tick;
  logic        col_wrap;
  logic [15:0] col_next;
  logic [15:0] row_next;
  region_t     h_state;
  region_t     v_state;
  region_t     h_next;
  region_t     v_next;
  logic        at_origin;

  // Next counter values and region states; everything registered below is derived from these.
  always_comb begin
    tick      = (div == DIV_LAST);
    col_wrap  = (column == H_LAST);
    col_next  = column;
    row_next  = row;
    h_next    = h_state;
    v_next    = v_state;
    if (tick) begin
      col_next = col_wrap ? 16'd0 : column + 16'd1;
      h_next   = next_region(h_state, col_next, H_FRONT_START, H_SYNC_START, H_BACK_START);
      if (col_wrap) begin
        row_next = (row == V_LAST) ? 16'd0 : row + 16'd1;
        v_next   = next_region(v_state, row_next, V_FRONT_START, V_SYNC_START, V_BACK_START);
      end
    end
    at_origin = tick && (col_next == 16'd0) && (row_next == 16'd0);
  end

  // Pixel-rate divider: wraps on the tick clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 16'd0;
    end else begin
      div <= tick ? 16'd0 : div + 16'd1;
    end
  end

  // Counters, region FSMs and all decoded outputs update together so there is no skew between them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      column      <= H_LAST;
      row         <= V_LAST;
      h_state     <= H_RESET_REGION;
      v_state     <= V_RESET_REGION;
      enable      <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pixel_tick  <= tick;
      frame_start <= at_origin;
      if (tick) begin
        column  <= col_next;
        row     <= row_next;
        h_state <= h_next;
        v_state <= v_next;
        enable  <= (h_next == ST_ACTIVE) && (v_next == ST_ACTIVE);
        hsync   <= (h_next == ST_SYNC) ? SYNC_ON : SYNC_IDLE;
        vsync   <= (v_next == ST_SYNC) ? SYNC_ON : SYNC_IDLE;
      end
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  // Frame counter steps on the same edge that raises frame_start; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (at_origin) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb/tb_vga_sync_generator.sv - self-checking bench for vga_sync_generator (default and small/fast configs)
module tb_vga_sync_generator;

  localparam int HA0 = 640, HF0 = 16, HS0 = 96, HB0 = 48;
  localparam int VA0 = 480, VF0 = 10, VS0 = 2, VB0 = 33, DIV0 = 2;
  localparam int HT0 = HA0 + HF0 + HS0 + HB0;
  localparam int VT0 = VA0 + VF0 + VS0 + VB0;
  localparam int HA1 = 8, HF1 = 2, HS1 = 3, HB1 = 2;
  localparam int VA1 = 6, VF1 = 1, VS1 = 2, VB1 = 1, DIV1 = 1;
  localparam int HT1 = HA1 + HF1 + HS1 + HB1;
  localparam int VT1 = VA1 + VF1 + VS1 + VB1;

  typedef struct packed {
    logic [15:0] row;
    logic [15:0] column;
    logic        enable;
    logic        hsync;
    logic        vsync;
    logic        pixel_tick;
    logic        frame_start;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] row0, col0, row1, col1;
  logic        en0, hs0, vs0, pt0, fs0;
  logic        en1, hs1, vs1, pt1, fs1;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] fc0, fc1;
  int          m_fc0 = 0, m_fc1 = 0;
`endif

  int   errors = 0;
  int   checks = 0;
  obs_t exp0_q[$];
  obs_t exp1_q[$];
  int   m_div0 = 0, m_col0 = HT0 - 1, m_row0 = VT0 - 1;
  int   m_div1 = 0, m_col1 = HT1 - 1, m_row1 = VT1 - 1;
  bit   m_tick0, m_fs0, m_tick1, m_fs1;
  int   n, hs_ticks, en_ticks, vs_cnt, hs_cnt, gap;

  always #5 clk = ~clk;

  vga_sync_generator dut (
    .clk(clk), .reset(rst), .row(row0), .column(col0), .enable(en0),
    .hsync(hs0), .vsync(vs0), .pixel_tick(pt0), .frame_start(fs0)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(fc0)
`endif
  );

  vga_sync_generator #(
    .H_ACTIVE(HA1), .H_FRONT(HF1), .H_SYNC(HS1), .H_BACK(HB1),
    .V_ACTIVE(VA1), .V_FRONT(VF1), .V_SYNC(VS1), .V_BACK(VB1),
    .CLK_DIV(DIV1), .SYNC_ACTIVE_LOW(1'b0)
  ) dut_s (
    .clk(clk), .reset(rst), .row(row1), .column(col1), .enable(en1),
    .hsync(hs1), .vsync(vs1), .pixel_tick(pt1), .frame_start(fs1)
`ifdef VGA_FRAME_COUNTER_EN
    , .frame_count(fc1)
`endif
  );

  function automatic obs_t expect_out(int c, int r, int ha, int hf, int hs, int va, int vf, int vs,
                                      bit low, bit pt, bit fs);
    obs_t o;
    o.row         = 16'(r);
    o.column      = 16'(c);
    o.enable      = (c < ha) && (r < va);
    o.hsync       = ((c >= ha + hf) && (c < ha + hf + hs)) ? !low : low;
    o.vsync       = ((r >= va + vf) && (r < va + vf + vs)) ? !low : low;
    o.pixel_tick  = pt;
    o.frame_start = fs;
    return o;
  endfunction

  task automatic model_adv(input int div_n, input int ht, input int vt,
                           inout int d, inout int c, inout int r, output bit t, output bit fs);
    t  = 1'b0;
    fs = 1'b0;
    if (rst) begin
      d = 0; c = ht - 1; r = vt - 1;
    end else begin
      t = (d == div_n - 1);
      d = t ? 0 : d + 1;
      if (t) begin
        if (c == ht - 1) begin
          c = 0;
          r = (r == vt - 1) ? 0 : r + 1;
        end else begin
          c = c + 1;
        end
        fs = (c == 0) && (r == 0);
      end
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic compare_outputs();
    obs_t e0, e1;
    e0 = exp0_q.pop_front();
    e1 = exp1_q.pop_front();
    check("dut0_outputs", 64'({row0, col0, en0, hs0, vs0, pt0, fs0}), 64'(e0));
    check("dut1_outputs", 64'({row1, col1, en1, hs1, vs1, pt1, fs1}), 64'(e1));
`ifdef VGA_FRAME_COUNTER_EN
    check("dut0_frame_count", 64'(fc0), 64'(m_fc0));
    check("dut1_frame_count", 64'(fc1), 64'(m_fc1));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_adv(DIV0, HT0, VT0, m_div0, m_col0, m_row0, m_tick0, m_fs0);
    model_adv(DIV1, HT1, VT1, m_div1, m_col1, m_row1, m_tick1, m_fs1);
`ifdef VGA_FRAME_COUNTER_EN
    if (rst) begin
      m_fc0 = 0; m_fc1 = 0;
    end else begin
      if (m_fs0) m_fc0 = (m_fc0 + 1) % 65536;
      if (m_fs1) m_fc1 = (m_fc1 + 1) % 65536;
    end
`endif
    exp0_q.push_back(expect_out(m_col0, m_row0, HA0, HF0, HS0, VA0, VF0, VS0, 1'b1, m_tick0, m_fs0));
    exp1_q.push_back(expect_out(m_col1, m_row1, HA1, HF1, HS1, VA1, VF1, VS1, 1'b0, m_tick1, m_fs1));
    #1;
    compare_outputs();
  endtask

  initial begin
    // Reset held for a few clocks
    repeat (3) step();
    check("rst_column", 64'(col0), 64'(799));
    check("rst_row", 64'(row0), 64'(524));
    check("rst_hsync_low_active", 64'(hs0), 64'(1));
    check("rst_vsync_low_active", 64'(vs0), 64'(1));
    check("rst_hsync_high_active", 64'(hs1), 64'(0));
    check("rst_vsync_high_active", 64'(vs1), 64'(0));

    // Release: default config ticks on the second clock
    rst = 1'b0;
    step();
    check("first_clk_no_tick", 64'(pt0), 64'(0));
    check("first_clk_hold_col", 64'(col0), 64'(799));
    check("fast_tick_every_clk", 64'(pt1), 64'(1));
    step();
    check("first_tick_col", 64'(col0), 64'(0));
    check("first_tick_row", 64'(row0), 64'(0));
    check("first_tick_enable", 64'(en0), 64'(1));
    check("first_tick_frame_start", 64'(fs0), 64'(1));
    check("first_tick_pixel_tick", 64'(pt0), 64'(1));
    step();
    check("pixel_tick_drops", 64'(pt0), 64'(0));

    // One full line of the default config
    hs_ticks = 0;
    en_ticks = 0;
    for (int i = 0; i < 2 * HT0; i++) begin
      step();
      if (pt0) begin
        if (!hs0) hs_ticks++;
        if (en0) en_ticks++;
        if (m_col0 == 639) check("enable_at_639", 64'(en0), 64'(1));
        if (m_col0 == 640) check("enable_at_640", 64'(en0), 64'(0));
      end
    end
    check("hsync_width", 64'(hs_ticks), 64'(96));
    check("enable_width", 64'(en_ticks), 64'(640));
    check("line_wrap_col", 64'(col0), 64'(0));
    check("line_wrap_row", 64'(row0), 64'(1));

    // Asynchronous reset in the middle of a line
    n = 0;
    while (m_col0 != 400 && n < 1000) begin
      step();
      n++;
    end
    check("reach_col_400", 64'(col0), 64'(400));
    #3 rst = 1'b1;
    #1;
    check("async_rst_col", 64'(col0), 64'(799));
    check("async_rst_row", 64'(row0), 64'(524));
    check("async_rst_enable", 64'(en0), 64'(0));
    check("async_rst_hsync", 64'(hs0), 64'(1));
    check("async_rst_hsync_fast", 64'(hs1), 64'(0));
    m_div0 = 0; m_col0 = HT0 - 1; m_row0 = VT0 - 1;
    m_div1 = 0; m_col1 = HT1 - 1; m_row1 = VT1 - 1;
`ifdef VGA_FRAME_COUNTER_EN
    m_fc0 = 0; m_fc1 = 0;
`endif
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    check("restart_frame_start", 64'(fs0), 64'(1));
    check("restart_origin", 64'({row0, col0}), 64'(0));

    // Full frames of the small config
    n = 0;
    while (!fs1 && n < 200) begin
      step();
      n++;
    end
    check("fast_frame_start_seen", 64'(fs1), 64'(1));
    vs_cnt = 0;
    hs_cnt = 0;
    gap = 0;
    for (int i = 1; i <= HT1 * VT1; i++) begin
      step();
      if (vs1) vs_cnt++;
      if (hs1) hs_cnt++;
      if (fs1 && gap == 0) gap = i;
    end
    check("frame_period", 64'(gap), 64'(HT1 * VT1));
    check("vsync_cycles", 64'(vs_cnt), 64'(VS1 * HT1));
    check("hsync_cycles", 64'(hs_cnt), 64'(HS1 * VT1));

`ifdef VGA_FRAME_COUNTER_EN
    force dut_s.frame_count = 16'hFFFF;
    m_fc1 = 65535;
    step();
    release dut_s.frame_count;
    n = 0;
    while (!fs1 && n < 200) begin
      step();
      n++;
    end
    check("frame_count_wrap", 64'(fc1), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
